// File: rtl/flog_pkg.sv
// Shared widths, FSM state type and exception codes for the bfloat16 log2 datapath.
package flog_pkg;

    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int BIAS        = 127;
    localparam int GUARD_BITS  = 4;

    // Squaring register: 1 integer bit plus FRACT_WIDTH+GUARD_BITS fraction bits.
    localparam int Y_WIDTH     = 1 + FRACT_WIDTH + GUARD_BITS;
    localparam int DATA_WIDTH  = 1 + EXP_WIDTH + FRACT_WIDTH;
    localparam int K_WIDTH     = $clog2(FRACT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } ss_F2I;

    typedef logic [1:0] exc_t;
    localparam exc_t EXC_NONE = 2'b00;
    localparam exc_t EXC_ZERO = 2'b01;
    localparam exc_t EXC_NAN  = 2'b10;
    localparam exc_t EXC_INF  = 2'b11;

endpackage

// File: rtl/f2i_log_sq_step.sv
// One log2 bit by squaring: y in [1,2) -> y*y in [1,4); renormalise and emit the bit.
module log_sq_step
    import flog_pkg::*;
(
    input  logic [Y_WIDTH-1:0] y_i,
    output logic [Y_WIDTH-1:0] y_o,
    output logic               bit_o
);

    logic [2*Y_WIDTH-1:0] sq;

    // sq has 2 integer bits; both selects truncate back to Y_WIDTH-1 fraction bits.
    assign sq    = y_i * y_i;
    assign bit_o = sq[2*Y_WIDTH-1];
    assign y_o   = bit_o ? sq[2*Y_WIDTH-1 -: Y_WIDTH] : sq[2*Y_WIDTH-2 -: Y_WIDTH];

endmodule

// File: rtl/f2i.sv
// bfloat16 -> {unbiased exponent, log2(1.m)} front end, one log bit per cycle.
// Optional macro F2I_EXC_FLAGS_EN adds exc_o and a valid pulse for special operands.
module f2i
    import flog_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_f2i_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    busy_o,
    output logic [EXP_WIDTH-1:0]    integer_o,
    output logic [FRACT_WIDTH-1:0]  log_f_o,
`ifdef F2I_EXC_FLAGS_EN
    output logic [1:0]              exc_o,
`endif
    output logic                    valid_f2i_o
);

    ss_F2I                  state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [Y_WIDTH-1:0]     y_q, y_d, y_next;
    logic [K_WIDTH-1:0]     k_q, k_d;
    logic [EXP_WIDTH-1:0]   int_q, int_d;
    logic [FRACT_WIDTH-1:0] log_q, log_d;
    exc_t                   exc_q, exc_d;
    logic                   log_bit;

    logic                   sgn;
    logic [EXP_WIDTH-1:0]   exp_f;
    logic [FRACT_WIDTH-1:0] fract_f;
    exc_t                   cls;

    assign {sgn, exp_f, fract_f} = data_q;

    // Subnormals flush to zero; any negative nonzero value has no real log.
    always_comb begin
        if (exp_f == '0)
            cls = EXC_ZERO;
        else if (exp_f == '1)
            cls = (fract_f != '0 || sgn) ? EXC_NAN : EXC_INF;
        else
            cls = sgn ? EXC_NAN : EXC_NONE;
    end

    log_sq_step u_step (
        .y_i   (y_q),
        .y_o   (y_next),
        .bit_o (log_bit)
    );

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        y_d     = y_q;
        k_d     = k_q;
        int_d   = int_q;
        log_d   = log_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: begin
                if (valid_f2i_i) begin
                    data_d  = data_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                exc_d = cls;
                if (cls == EXC_NONE) begin
                    int_d   = exp_f - EXP_WIDTH'(BIAS);
                    y_d     = {1'b1, fract_f, {GUARD_BITS{1'b0}}};
                    k_d     = K_WIDTH'(FRACT_WIDTH - 1);
                    state_d = ITER;
                end else begin
`ifdef F2I_EXC_FLAGS_EN
                    int_d   = '0;
                    log_d   = '0;
                    state_d = DONE;
`else
                    state_d = IDLE;
`endif
                end
            end
            ITER: begin
                log_d[k_q] = log_bit;
                y_d        = y_next;
                if (k_q == '0)
                    state_d = DONE;
                else
                    k_d = k_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            y_q     <= '0;
            k_q     <= '0;
            int_q   <= '0;
            log_q   <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            y_q     <= y_d;
            k_q     <= k_d;
            int_q   <= int_d;
            log_q   <= log_d;
            exc_q   <= exc_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign valid_f2i_o = (state_q == DONE);
    assign integer_o   = int_q;
    assign log_f_o     = log_q;
`ifdef F2I_EXC_FLAGS_EN
    assign exc_o       = exc_q;
`else
    // exc_q only reaches a port in the flagged build.
    logic unused_exc;
    assign unused_exc  = ^exc_q;
`endif

endmodule

// File: tb/tb_f2i.sv
// Directed self-checking bench for f2i; also covers the F2I_EXC_FLAGS_EN build.
module tb_f2i;
    import flog_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_f2i_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        busy_o;
    logic [7:0]  integer_o;
    logic [6:0]  log_f_o;
    logic        valid_f2i_o;
`ifdef F2I_EXC_FLAGS_EN
    logic [1:0]  exc_o;
`endif

    int tests  = 0;
    int failed = 0;

    f2i dut (
        .clk         (clk),
        .rst         (rst),
        .valid_f2i_i (valid_f2i_i),
        .data_i      (data_i),
        .busy_o      (busy_o),
        .integer_o   (integer_o),
        .log_f_o     (log_f_o),
`ifdef F2I_EXC_FLAGS_EN
        .exc_o       (exc_o),
`endif
        .valid_f2i_o (valid_f2i_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue one operand at edge 0, then watch cycles 1..11 (sampled 1 ns after each edge).
    // exp_lat = 0 means no valid pulse is expected. inject > 0 raises a stray valid in that cycle.
    task automatic run_op(input string tag, input logic [15:0] d, input int exp_lat,
                          input logic [7:0] ei, input logic [6:0] el, input logic [1:0] ee,
                          input int inject);
        int pulses    = 0;
        int first     = 0;
        int busy_bad  = 0;
        logic [7:0] got_i = '0;
        logic [6:0] got_l = '0;
        logic [1:0] got_e = '0;
        @(negedge clk);
        data_i      = d;
        valid_f2i_i = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            valid_f2i_i = (c == inject);
            if (c == inject) data_i = 16'h4040;
            if (valid_f2i_o) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    got_i = integer_o;
                    got_l = log_f_o;
`ifdef F2I_EXC_FLAGS_EN
                    got_e = exc_o;
`endif
                end
            end
            if (exp_lat != 0 && c <= exp_lat && !busy_o) busy_bad++;
            if (exp_lat != 0 && c > exp_lat && busy_o) busy_bad++;
        end
        valid_f2i_i = 1'b0;
        check({tag, " pulses"}, pulses, (exp_lat != 0) ? 1 : 0);
        check({tag, " busy"}, busy_bad, 0);
        if (exp_lat != 0) begin
            check({tag, " latency"}, first, exp_lat);
            check({tag, " integer"}, int'(got_i), int'(ei));
            check({tag, " log_f"}, int'(got_l), int'(el));
`ifdef F2I_EXC_FLAGS_EN
            check({tag, " exc"}, int'(got_e), int'(ee));
`else
            got_e = ee;
`endif
        end
    endtask

    initial begin
        int lat_spec;
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", int'(busy_o), 0);
        check("rst integer", int'(integer_o), 0);
        check("rst log_f", int'(log_f_o), 0);
        check("rst valid", int'(valid_f2i_o), 0);
`ifdef F2I_EXC_FLAGS_EN
        check("rst exc", int'(exc_o), 0);
`endif
        rst = 1'b0;

        // Normal operands, 12-cycle spacing back to back
        run_op("one",   16'h3F80, 9, 8'h00, 7'h00, 2'b00, 0);
        run_op("1p5",   16'h3FC0, 9, 8'h00, 7'h4A, 2'b00, 0);
        run_op("three", 16'h4040, 9, 8'h01, 7'h4A, 2'b00, 0);
        run_op("half",  16'h3F00, 9, 8'hFF, 7'h00, 2'b00, 0);
        run_op("max",   16'h7F00, 9, 8'h7F, 7'h00, 2'b00, 0);
        run_op("min",   16'h0080, 9, 8'h82, 7'h00, 2'b00, 0);

        // Stray valid during ITER must be ignored
        run_op("inject", 16'h3FC0, 9, 8'h00, 7'h4A, 2'b00, 4);

        // Special operands
`ifdef F2I_EXC_FLAGS_EN
        lat_spec = 2;
`else
        lat_spec = 0;
`endif
        run_op("zero",   16'h0000, lat_spec, 8'h00, 7'h00, 2'b01, 0);
        run_op("negz",   16'h8000, lat_spec, 8'h00, 7'h00, 2'b01, 0);
        run_op("neg",    16'hBF80, lat_spec, 8'h00, 7'h00, 2'b10, 0);
        run_op("inf",    16'h7F80, lat_spec, 8'h00, 7'h00, 2'b11, 0);
        run_op("nan",    16'h7FC1, lat_spec, 8'h00, 7'h00, 2'b10, 0);
        run_op("after",  16'h4040, 9, 8'h01, 7'h4A, 2'b00, 0);

        // Reset in the middle of ITER
        @(negedge clk);
        data_i      = 16'h3FC0;
        valid_f2i_i = 1'b1;
        @(posedge clk);
        #1;
        valid_f2i_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid busy before", int'(busy_o), 1);
        rst = 1'b1;
        #1;
        check("mid rst busy", int'(busy_o), 0);
        check("mid rst integer", int'(integer_o), 0);
        check("mid rst log_f", int'(log_f_o), 0);
        check("mid rst valid", int'(valid_f2i_o), 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int pulses = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (valid_f2i_o) pulses++;
            end
            check("mid rst no pulse", pulses, 0);
        end
        run_op("post rst", 16'h3FC0, 9, 8'h00, 7'h4A, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/f2i.md
Name: f2i

Overview:
- Front-end stage of the bfloat16 log2 datapath; sits directly upstream of the integer/log-fraction to float converter.
- Accepts one bfloat16 operand and splits log2(x) into two fields:
  - a signed integer part: unbiased exponent, EXP_WIDTH-bit two's complement;
  - a FRACT_WIDTH-bit log2 of the mantissa 1.m, computed bit-serially by iterative squaring.
- Output pair and valid pulse drive the converter's integer/log-fraction inputs and valid input directly.

Parameters:
- EXP_WIDTH, 8, exponent field width (from flog_pkg).
- FRACT_WIDTH, 7, mantissa field width = number of log-fraction bits produced (from flog_pkg).
- BIAS, 127, exponent bias (from flog_pkg).
- GUARD_BITS, 4, extra fraction bits kept in the squaring register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_f2i_i  in  1  operand valid; sampled only in IDLE.
- data_i  in  1+EXP_WIDTH+FRACT_WIDTH  bfloat16 operand {sgn, exp, fract}.
- busy_o  out  1  high whenever state is not IDLE.
- integer_o  out  EXP_WIDTH  exp − BIAS, two's complement.
- log_f_o  out  FRACT_WIDTH  log2(1.fract), MSB-first binary fraction, truncated.
- valid_f2i_o  out  1  one-cycle result pulse.

Behaviour:
- Reset:
  - busy_o=0, integer_o=0, log_f_o=0, valid_f2i_o=0.
  - State returns to IDLE; all internal registers cleared.
  - An operation interrupted by reset is discarded with no valid pulse.
- FSM states: IDLE, CHECK, ITER, DONE.
- IDLE:
  - On valid_f2i_i=1, register data_i and go to CHECK.
  - valid_f2i_i while busy is ignored; it is neither queued nor flagged.
- CHECK: classify the registered operand and load the datapath.
  - Normal (exp≠0, exp≠all-ones, sgn=0):
    - integer_o ← exp − BIAS, exact in EXP_WIDTH bits, range −126..+127.
    - y ← {1, fract, GUARD_BITS zeros}: 1 integer bit, FRACT_WIDTH+GUARD_BITS fraction bits.
    - Iteration counter k ← FRACT_WIDTH−1; go to ITER.
  - Special: zero or subnormal (flushed to zero), sgn=1 with nonzero value, exp all-ones. Handling is defined under Optional Feature.
- ITER, one log bit per cycle:
  - s = y·y, full width (2 integer bits).
  - If s ≥ 2: log_f_o[k] ← 1, y ← s>>1. Otherwise log_f_o[k] ← 0, y ← s.
  - y is truncated, not rounded, back to FRACT_WIDTH+GUARD_BITS fraction bits.
  - When k=0, go to DONE; otherwise decrement k.
- DONE:
  - valid_f2i_o=1 for exactly one cycle, then IDLE.
  - integer_o and log_f_o hold their values until the next operation's CHECK/ITER writes.
- Latency and throughput:
  - Normal operand: valid_f2i_i sampled at edge 0 gives valid_f2i_o high in cycle FRACT_WIDTH+2 (9 cycles by default).
  - Throughput is 1 operand per FRACT_WIDTH+3 cycles.
  - A new valid_f2i_i is accepted in the cycle after DONE.
- Sign handling: −0 is treated as zero.

Optional Feature:
- Macro: F2I_EXC_FLAGS_EN.
- Defined:
  - Adds port exc_o, out, 2 bits: 00 normal, 01 zero (log=−inf), 10 NaN (NaN input or negative nonzero), 11 +inf.
  - exc_o is 00 at reset and updated in CHECK.
  - Special operands skip ITER: CHECK → DONE, so the valid pulse arrives in cycle 2.
  - For special operands, integer_o and log_f_o are forced to 0.
- Undefined:
  - exc_o is absent.
  - Special operands go CHECK → IDLE and produce no valid_f2i_o pulse.

Decomposition:
- Shared in flog_pkg:
  - EXP_WIDTH, FRACT_WIDTH, BIAS, GUARD_BITS.
  - FSM enum type ss_F2I.
  - exc code typedef exc_t with constants EXC_NONE, EXC_ZERO, EXC_NAN, EXC_INF.
- One sub-module is natural: log_sq_step. It is combinational: input y, output next y and the log bit (square, compare, conditional shift).

Test Plan:
- 0x3F80 (1.0) → integer_o=0x00, log_f_o=0x00, valid_f2i_o in cycle 9 after sampling.
- 0x3FC0 (1.5) → integer_o=0x00, log_f_o=0x4A; 0x4040 (3.0) → integer_o=0x01, log_f_o=0x4A.
- 0x3F00 (0.5) → integer_o=0xFF, log_f_o=0x00; 0x7F00 → integer_o=0x7F.
- Second valid_f2i_i pulse during ITER → ignored; busy_o=1 throughout; exactly one valid_f2i_o; back-to-back operands accepted at 12-cycle spacing.
- Special inputs:
  - With F2I_EXC_FLAGS_EN: 0x0000 → exc 01; 0xBF80 → 10; 0x7F80 → 11; 0x7FC1 → 10; each with valid_f2i_o in cycle 2.
  - Without the macro: the same inputs give no valid_f2i_o.
- rst asserted mid-ITER → outputs 0 immediately, no valid pulse; next operand processed correctly.
